sdram_req_bridge: RTL
=====================

SDRAM_REQ_BRIDGE -- requirements
Module: sdram_req_bridge

Interface
REQ-001 SHALL have port: clk  in  1  system clock, 64 MHz, same clock as the SDRAM controller.
REQ-002 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: cpu_req  in  1  single-cycle request strobe.
REQ-004 SHALL have port: cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
REQ-005 SHALL have port: cpu_addr  in  24  byte address; sampled with cpu_req.
REQ-006 SHALL have port: cpu_wdata  in  8  write byte; sampled with cpu_req.
REQ-007 SHALL have port: cpu_rdata  out  8  read byte; valid while cpu_ready=1 and held until the next read completes.
REQ-008 SHALL have port: cpu_ready  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: busy  out  1  request outstanding.
REQ-010 SHALL have controller-side ports: sync out 1; addr out 24 (word address); din out 16; ds out 2; oe out 1; we out 1; dout in 16; ack in 1.

Function
REQ-011 SHALL run a free-running 3-bit phase counter ph (0..7); sync SHALL be 1 only when ph==0.
REQ-012 SHALL use states IDLE, PEND, WIN, DONE.
REQ-013 IDLE: on cpu_req, latch we/addr/wdata, set busy, go to PEND; cpu_req while busy=1 SHALL be ignored.
REQ-014 PEND: at ph==0, drive controller signals and go to WIN; otherwise hold.
REQ-015 Word mapping: addr = {1'b0, cpu_addr[23:1]}; byte lane: cpu_addr[0]=0 -> ds=01, low byte; cpu_addr[0]=1 -> ds=10, high byte.
REQ-016 Write: din = {wdata, wdata}; we=1 from ph0 through ph7 of exactly one window, then 0; write completes at ph7 without waiting for ack.
REQ-017 Read: oe=1 and addr stable from ph0. At ph7, if ack=1, latch the selected byte of dout into cpu_rdata and go to DONE. If ack=0, hold oe/addr for another full window.
REQ-018 DONE: pulse cpu_ready for 1 cycle, drop oe/we/busy, return to IDLE.
REQ-019 oe and we SHALL never be 1 simultaneously; both SHALL be 0 in IDLE.
REQ-020 Latency from cpu_req to cpu_ready SHALL be 9..16 cycles for a write or a read acknowledged in its first window; each extra read window adds 8 cycles.
REQ-021 cpu_req arriving exactly at ph==0 in IDLE SHALL launch at the next ph==0, 8 cycles later; it SHALL NOT launch in the same cycle.

Reset
REQ-022 reset_n=0 SHALL force ph=0, state=IDLE, and all outputs to 0: sync, oe, we, addr, din, ds, cpu_rdata, cpu_ready, busy.
REQ-023 Reset mid-window SHALL drop oe/we immediately and discard the request; no cpu_ready SHALL follow.

Configuration
REQ-024 Macro SDRAM_REQ_BRIDGE_READ_BUF_EN SHALL add a one-word read buffer holding a tag (word address), data (16 bits), and a valid bit.
REQ-025 With the macro defined:
- A read whose word address matches the tag while valid=1 SHALL skip SDRAM access and pulse cpu_ready 2 cycles after cpu_req.
- A completed SDRAM read SHALL fill the buffer.
- A write to the tagged word SHALL update the written byte in the buffer.
- Reset SHALL clear valid.
REQ-026 Without the macro, every read SHALL go through SDRAM per REQ-017.

Verification
REQ-027 Write 0x3C to byte addr 0x000101 -> one window with we=1, addr=0x000080, ds=10, din=0x3C3C; cpu_ready at ph7+1; oe stays 0.
REQ-028 Read byte addr 0x000100, controller returns dout=0xA55A with ack at ph7 -> cpu_rdata=0x5A; no second window.
REQ-029 Read with ack=0 in the first window and 1 in the second -> oe held 16 cycles with addr constant; cpu_ready 8 cycles later than REQ-028.
REQ-030 cpu_req pulsed again while busy -> ignored; exactly one cpu_ready is produced.
REQ-031 reset_n low at ph3 of a read window -> oe=0 at once, no cpu_ready, ph restarts at 0.
REQ-032 READ_BUF_EN defined: read 0x000100 then 0x000101 -> second read returns the high byte of 0xA55A (0xA5) with no oe pulse, 2-cycle latency.

Source files
------------

// File: rtl/sdram_req_bridge.sv
// rtl/sdram_req_bridge.sv - byte-wide CPU request bridge onto an 8-phase 16-bit SDRAM controller slot
// Optional one-word read buffer: define SDRAM_REQ_BRIDGE_READ_BUF_EN.
module sdram_req_bridge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        busy,
  output logic        sync,
  output logic [23:0] addr,
  output logic [15:0] din,
  output logic [1:0]  ds,
  output logic        oe,
  output logic        we,
  input  logic [15:0] dout,
  input  logic        ack
);

  typedef enum logic [1:0] {IDLE, PEND, WIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ph_q;
  logic        we_lat_q, we_lat_d;
  logic [23:0] addr_lat_q, addr_lat_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hit_q, hit_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  ds_q, ds_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        launch_now;
  logic        src_we;
  logic [23:0] src_addr;
  logic [7:0]  src_wdata;
  logic        buf_hit;
  logic [7:0]  buf_byte;

  // Outputs are registered, so a window is launched on the ph7 edge to be live at ph0.
  assign src_we    = (state_q == PEND) ? we_lat_q   : cpu_we;
  assign src_addr  = (state_q == PEND) ? addr_lat_q : cpu_addr;
  assign src_wdata = (state_q == PEND) ? wdata_q    : cpu_wdata;

  assign sync      = reset_n & (ph_q == 3'd0);
  assign cpu_ready = (state_q == DONE);
  assign busy      = (state_q == PEND) || (state_q == WIN);
  assign cpu_rdata = rdata_q;
  assign oe        = oe_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign ds        = ds_q;

`ifdef SDRAM_REQ_BRIDGE_READ_BUF_EN
  logic [22:0] buf_tag_q;
  logic [15:0] buf_data_q;
  logic        buf_valid_q;
  logic        win_end;

  assign win_end  = (state_q == WIN) && (ph_q == 3'd7);
  assign buf_hit  = buf_valid_q && !cpu_we && (buf_tag_q == cpu_addr[23:1]);
  assign buf_byte = addr_lat_q[0] ? buf_data_q[15:8] : buf_data_q[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else if (win_end && !we_q && ack) begin
      buf_tag_q   <= addr_q[22:0];
      buf_data_q  <= dout;
      buf_valid_q <= 1'b1;
    end else if (win_end && we_q && buf_valid_q && (buf_tag_q == addr_q[22:0])) begin
      if (addr_lat_q[0]) buf_data_q[15:8] <= wdata_q;
      else               buf_data_q[7:0]  <= wdata_q;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_byte = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    we_lat_d   = we_lat_q;
    addr_lat_d = addr_lat_q;
    wdata_d    = wdata_q;
    hit_d      = hit_q;
    oe_d       = oe_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    ds_d       = ds_q;
    rdata_d    = rdata_q;
    launch_now = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (cpu_req) begin
          we_lat_d   = cpu_we;
          addr_lat_d = cpu_addr;
          wdata_d    = cpu_wdata;
          hit_d      = buf_hit;
          if (!buf_hit && (ph_q == 3'd7)) begin
            state_d    = WIN;
            launch_now = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (hit_q) begin
          state_d = DONE;
          rdata_d = buf_byte;
        end else if (ph_q == 3'd7) begin
          state_d    = WIN;
          launch_now = 1'b1;
        end
      end
      WIN: begin
        // Writes are fire-and-forget; reads retry whole windows until acked.
        if (ph_q == 3'd7) begin
          if (we_q) begin
            we_d    = 1'b0;
            state_d = DONE;
          end else if (ack) begin
            oe_d    = 1'b0;
            rdata_d = addr_lat_q[0] ? dout[15:8] : dout[7:0];
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch_now) begin
      addr_d = {1'b0, src_addr[23:1]};
      ds_d   = src_addr[0] ? 2'b10 : 2'b01;
      din_d  = {src_wdata, src_wdata};
      we_d   = src_we;
      oe_d   = ~src_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q       <= 3'd0;
      state_q    <= IDLE;
      we_lat_q   <= 1'b0;
      addr_lat_q <= '0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ds_q       <= '0;
      rdata_q    <= '0;
    end else begin
      ph_q       <= ph_q + 3'd1;
      state_q    <= state_d;
      we_lat_q   <= we_lat_d;
      addr_lat_q <= addr_lat_d;
      wdata_q    <= wdata_d;
      hit_q      <= hit_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ds_q       <= ds_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
